// File: rtl/elevator_pkg.sv
// Shared constants for the elevator call panel and the controller display.
package elevator_pkg;

    localparam int N_CALL = 4;

    // Call index to floor-bit position: F1, F3, F6, F8.
    localparam logic [2:0] FLOOR_BIT [N_CALL] = '{3'd0, 3'd2, 3'd5, 3'd7};

    // Seven-segment floor digits 1..8 (gfedcba), shared with the controller display.
    localparam logic [6:0] FLOOR_SEG [8] = '{
        7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F
    };

    // Spread a per-call-index set into floor-bit space.
    function automatic logic [7:0] to_floor_bits(input logic [N_CALL-1:0] idx_set);
        logic [7:0] f;
        f = '0;
        for (int i = 0; i < N_CALL; i++) begin
            f[FLOOR_BIT[i]] = idx_set[i];
        end
        return f;
    endfunction

endpackage

// File: rtl/elevator_call_panel_btn_debounce.sv
// Two-flop synchroniser plus counting debouncer; emits a one-cycle pulse on an accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Synchronise, count consecutive disagreeing cycles, and accept the new level after the window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                rise   <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_call_panel.sv
// Hall/car call front end: debounced presses latch floor requests, service at the floor clears them.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_on,
    input  logic [3:0] hall_btn,
    input  logic [3:0] car_btn,
    input  logic [7:0] cur_floor,
    input  logic       door_open_st,
    output logic [7:0] req_floor,
    output logic [3:0] hall_lamp,
    output logic [3:0] car_lamp,
    output logic       req_any,
    output logic       req_pulse
);

    logic [N_CALL-1:0] hall_rise;
    logic [N_CALL-1:0] car_rise;
    logic [N_CALL-1:0] svc;
    logic [N_CALL-1:0] pending;
    logic [N_CALL-1:0] pending_nxt;
    logic [N_CALL-1:0] hall_nxt;
    logic [N_CALL-1:0] car_nxt;

    for (genvar g = 0; g < N_CALL; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_hall (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (hall_btn[g]),
            .rise (hall_rise[g])
        );

        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_car (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (car_btn[g]),
            .rise (car_rise[g])
        );
    end

    // A floor is serviced only by an exact one-hot match with the door open.
    always_comb begin
        svc = '0;
        for (int i = 0; i < N_CALL; i++) begin
            svc[i] = door_open_st && (cur_floor == (8'd1 << FLOOR_BIT[i]));
        end
    end

    // Service wins over a press at the same index; presses elsewhere still land.
    always_comb begin
        pending_nxt = pending;
        hall_nxt    = hall_lamp;
        car_nxt     = car_lamp;
        for (int i = 0; i < N_CALL; i++) begin
            if (svc[i]) begin
                pending_nxt[i] = 1'b0;
                hall_nxt[i]    = 1'b0;
                car_nxt[i]     = 1'b0;
            end else begin
                if (hall_rise[i]) begin
                    pending_nxt[i] = 1'b1;
                    hall_nxt[i]    = 1'b1;
                end
                if (car_rise[i]) begin
                    pending_nxt[i] = 1'b1;
                    car_nxt[i]     = 1'b1;
                end
            end
        end
    end

    // Register request state and all outputs; power-off holds everything cleared.
    always_ff @(posedge clk) begin
        if (!rst_n || !power_on) begin
            pending   <= '0;
            hall_lamp <= '0;
            car_lamp  <= '0;
            req_floor <= '0;
            req_any   <= 1'b0;
            req_pulse <= 1'b0;
        end else begin
            pending   <= pending_nxt;
            hall_lamp <= hall_nxt;
            car_lamp  <= car_nxt;
            req_floor <= to_floor_bits(pending_nxt);
            req_any   <= |pending_nxt;
            req_pulse <= |(pending_nxt & ~pending);
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed table-driven bench for elevator_call_panel with a short debounce window.
module tb_elevator_call_panel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       power_on;
    logic [3:0] hall_btn;
    logic [3:0] car_btn;
    logic [7:0] cur_floor;
    logic       door_open_st;
    logic [7:0] req_floor;
    logic [3:0] hall_lamp;
    logic [3:0] car_lamp;
    logic       req_any;
    logic       req_pulse;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] hall;
        logic [3:0] car;
        logic [7:0] cur;
        logic       door;
        logic       pwr;
        int         n;
        logic [7:0] e_req;
        logic [3:0] e_hall;
        logic [3:0] e_car;
        logic       e_pulse;
    } vec_t;

    vec_t tbl[$];

    elevator_call_panel #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .power_on    (power_on),
        .hall_btn    (hall_btn),
        .car_btn     (car_btn),
        .cur_floor   (cur_floor),
        .door_open_st(door_open_st),
        .req_floor   (req_floor),
        .hall_lamp   (hall_lamp),
        .car_lamp    (car_lamp),
        .req_any     (req_any),
        .req_pulse   (req_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_req, input logic [3:0] e_hall,
                           input logic [3:0] e_car, input logic e_pulse);
        chk({tag, ".req_floor"}, req_floor, e_req);
        chk({tag, ".hall_lamp"}, {4'h0, hall_lamp}, {4'h0, e_hall});
        chk({tag, ".car_lamp"}, {4'h0, car_lamp}, {4'h0, e_car});
        chk({tag, ".req_any"}, {7'h0, req_any}, {7'h0, (e_req != 8'h00)});
        chk({tag, ".req_pulse"}, {7'h0, req_pulse}, {7'h0, e_pulse});
    endtask

    task automatic add(input logic [3:0] h, input logic [3:0] c, input logic [7:0] cur,
                       input logic door, input logic pwr, input int n, input logic [7:0] e_req,
                       input logic [3:0] e_hall, input logic [3:0] e_car, input logic e_pulse);
        vec_t v;
        v.hall = h; v.car = c; v.cur = cur; v.door = door; v.pwr = pwr; v.n = n;
        v.e_req = e_req; v.e_hall = e_hall; v.e_car = e_car; v.e_pulse = e_pulse;
        tbl.push_back(v);
    endtask

    initial begin
        //   hall  car   cur    door pwr  n   req    hall  car   pulse
        add(4'h0, 4'h0, 8'h00, 0,   1,  20, 8'h00, 4'h0, 4'h0, 0); // idle
        add(4'h0, 4'h4, 8'h00, 0,   1,   6, 8'h00, 4'h0, 4'h0, 0); // F6 car, one short of latency
        add(4'h0, 4'h4, 8'h00, 0,   1,   1, 8'h20, 4'h0, 4'h4, 1); // lands at k+7
        add(4'h0, 4'h0, 8'h00, 0,   1,  10, 8'h20, 4'h0, 4'h4, 0); // release: no event
        add(4'h1, 4'h0, 8'h00, 0,   1,   3, 8'h20, 4'h0, 4'h4, 0); // 3-cycle glitch
        add(4'h0, 4'h0, 8'h00, 0,   1,  10, 8'h20, 4'h0, 4'h4, 0); // glitch rejected
        add(4'h1, 4'h0, 8'h00, 0,   1,   4, 8'h20, 4'h0, 4'h4, 0); // exactly the window
        add(4'h0, 4'h0, 8'h00, 0,   1,  10, 8'h21, 4'h1, 4'h4, 0); // accepted
        add(4'h0, 4'h0, 8'h01, 1,   1,   1, 8'h20, 4'h0, 4'h4, 0); // service F1
        add(4'h8, 4'h8, 8'h00, 0,   1,   7, 8'hA0, 4'h8, 4'hC, 1); // F8 hall + car
        add(4'h0, 4'h0, 8'h00, 0,   1,  10, 8'hA0, 4'h8, 4'hC, 0);
        add(4'h0, 4'h0, 8'h80, 0,   1,   3, 8'hA0, 4'h8, 4'hC, 0); // door closed: no service
        add(4'h0, 4'h0, 8'h81, 1,   1,   3, 8'hA0, 4'h8, 4'hC, 0); // not one-hot: no service
        add(4'h0, 4'h0, 8'h80, 1,   1,   1, 8'h20, 4'h0, 4'h4, 0); // service F8
        add(4'h8, 4'h0, 8'h80, 1,   1,   7, 8'h20, 4'h0, 4'h4, 0); // press during service ignored
        add(4'h8, 4'h0, 8'h00, 0,   1,   3, 8'h20, 4'h0, 4'h4, 0); // held across service
        add(4'h0, 4'h0, 8'h00, 0,   1,  10, 8'h20, 4'h0, 4'h4, 0);
        add(4'h0, 4'h0, 8'h00, 0,   0,   1, 8'h00, 4'h0, 4'h0, 0); // power off clears
        add(4'h0, 4'h0, 8'h00, 0,   1,   5, 8'h00, 4'h0, 4'h0, 0);
        add(4'h0, 4'h1, 8'h00, 0,   0,  10, 8'h00, 4'h0, 4'h0, 0); // press while off
        add(4'h0, 4'h1, 8'h00, 0,   1,   5, 8'h00, 4'h0, 4'h0, 0); // held through power-up
        add(4'h0, 4'h0, 8'h00, 0,   1,  10, 8'h00, 4'h0, 4'h0, 0);
        add(4'hF, 4'h0, 8'h00, 0,   1,   7, 8'hA5, 4'hF, 4'h0, 1); // all four floors
        add(4'h0, 4'h0, 8'h00, 0,   1,  10, 8'hA5, 4'hF, 4'h0, 0);
        add(4'h0, 4'h0, 8'h00, 0,   0,   1, 8'h00, 4'h0, 4'h0, 0); // one-cycle power drop
        add(4'h0, 4'h0, 8'h00, 0,   1,   2, 8'h00, 4'h0, 4'h0, 0);

        rst_n = 1'b0; power_on = 1'b1; hall_btn = '0; car_btn = '0;
        cur_floor = '0; door_open_st = 1'b0;
        tick(3);
        chk_all("reset", 8'h00, 4'h0, 4'h0, 0);
        rst_n = 1'b1;

        foreach (tbl[r]) begin
            hall_btn = tbl[r].hall; car_btn = tbl[r].car; cur_floor = tbl[r].cur;
            door_open_st = tbl[r].door; power_on = tbl[r].pwr;
            tick(tbl[r].n);
            chk_all($sformatf("row%0d", r), tbl[r].e_req, tbl[r].e_hall, tbl[r].e_car, tbl[r].e_pulse);
        end

        // req_pulse is high for exactly one cycle, seven edges after the press.
        car_btn = 4'h4;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            chk($sformatf("pulse_t%0d", t), {7'h0, req_pulse}, {7'h0, (t == 7)});
        end
        chk("press_req", req_floor, 8'h20);
        car_btn = 4'h0;
        tick(10);

        // Second source on an already-pending floor: lamp only, no pulse.
        hall_btn = 4'h4;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            chk($sformatf("dup_pulse_t%0d", t), {7'h0, req_pulse}, 8'h00);
        end
        chk_all("dup", 8'h20, 4'h4, 4'h4, 0);
        hall_btn = 4'h0;
        tick(10);

        // Clear F6, then F3 press lands in the same cycle as F1 service.
        cur_floor = 8'h20; door_open_st = 1'b1;
        tick(1);
        chk_all("svc_f6", 8'h00, 4'h0, 4'h0, 0);
        cur_floor = 8'h00; door_open_st = 1'b0;
        hall_btn = 4'h1;
        tick(7);
        chk_all("f1_press", 8'h01, 4'h1, 4'h0, 1);
        hall_btn = 4'h0;
        tick(10);
        car_btn = 4'h2;
        tick(6);
        chk("simul_pre", req_floor, 8'h01);
        cur_floor = 8'h01; door_open_st = 1'b1;
        tick(1);
        chk_all("simul", 8'h04, 4'h0, 4'h2, 1);
        cur_floor = 8'h00; door_open_st = 1'b0; car_btn = 4'h0;
        tick(10);

        // Reset mid-debounce discards partial progress.
        hall_btn = 4'h8;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk_all("rst_mid", 8'h00, 4'h0, 4'h0, 0);
        rst_n = 1'b1; hall_btn = 4'h0;
        tick(15);
        chk_all("rst_release", 8'h00, 4'h0, 4'h0, 0);
        hall_btn = 4'h8;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        hall_btn = 4'h0;
        tick(12);
        chk_all("rst_short_hold", 8'h00, 4'h0, 4'h0, 0);
        hall_btn = 4'h8;
        tick(7);
        chk_all("rst_full_hold", 8'h80, 4'h8, 4'h0, 1);
        hall_btn = 4'h0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
